// File: rtl/ble_cmd_seq_if.sv
// Command-byte ingress and UART_tx start/done handshake of the BLE command sequencer.
// master: the sequencer itself; slave: whatever feeds bytes and plays UART_tx.
interface ble_cmd_seq_if;
    logic       push;
    logic [7:0] push_data;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (
        input  push,
        input  push_data,
        input  tx_done,
        output trmt,
        output tx_data
    );

    modport slave (
        output push,
        output push_data,
        output tx_done,
        input  trmt,
        input  tx_data
    );
endinterface

// File: rtl/ble_cmd_seq.sv
// BLE command sequencer: queues bytes, feeds UART_tx one at a time; push-to-trmt is 2 cycles into an idle queue.
// No backpressure: a push into a full queue without a same-cycle pop is dropped and flagged in ovf_err.
module ble_cmd_seq #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 16,
    parameter int TIMEOUT = 32768
) (
    input  logic           clk,
    input  logic           rst,
    ble_cmd_seq_if.master  bus,
    input  logic           clr_err,
    output logic           full,
    output logic           empty,
    output logic           busy,
    output logic [7:0]     sent_cnt,
    output logic           ovf_err,
    output logic           to_err
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_nxt;
    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [TW-1:0]   tmr;
    logic [7:0]      tx_data_q;

    logic pop;
    logic push_ok;
    logic push_drop;
    logic done_ok;
    logic timeout_hit;
    logic gap_end;

    // A pop frees a slot in the same cycle, so a push into a full queue still lands.
    always_comb begin
        pop         = (state == S_IDLE) && !empty;
        push_ok     = bus.push && ((count != CNTW'(DEPTH)) || pop);
        push_drop   = bus.push && !push_ok;
        count_nxt   = count + CNTW'(push_ok) - CNTW'(pop);
        done_ok     = (state == S_WAIT) && (tmr != '0) && bus.tx_done;
        timeout_hit = (state == S_WAIT) && !done_ok && (tmr == TW'(TIMEOUT - 1));
        gap_end     = (state == S_GAP) && (tmr == TW'(GAP - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_WAIT;
            S_WAIT:  if (done_ok || timeout_hit) state_nxt = S_GAP;
            S_GAP:   if (gap_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Storage carries no reset; occupancy is tracked solely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            tx_data_q <= 8'h00;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                tx_data_q <= mem[rd_ptr];
            end
            count <= count_nxt;
            full  <= (count_nxt == CNTW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // One timer serves both the tx_done wait and the inter-byte gap; it restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                tmr <= '0;
            else if (state == S_WAIT || state == S_GAP)
                tmr <= tmr + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_cnt <= 8'd0;
            ovf_err  <= 1'b0;
            to_err   <= 1'b0;
        end else begin
            if (done_ok) sent_cnt <= sent_cnt + 8'd1;

            if (push_drop)    ovf_err <= 1'b1;
            else if (clr_err) ovf_err <= 1'b0;

            if (timeout_hit)  to_err <= 1'b1;
            else if (clr_err) to_err <= 1'b0;
        end
    end

    assign bus.trmt    = (state == S_LOAD);
    assign bus.tx_data = tx_data_q;
    assign busy        = (state != S_IDLE);

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNTW'(DEPTH));
    a_data_stable: assert property (@(posedge clk) disable iff (rst)
        (state == S_WAIT) |-> $stable(tx_data_q));
    a_full_tracks: assert property (@(posedge clk) disable iff (rst)
        full == (count == CNTW'(DEPTH)));

endmodule

// File: tb/tb_ble_cmd_seq.sv
// Directed bench for ble_cmd_seq with a behavioural UART_tx stand-in (fixed frame length, lagging tx_done clear).
module tb_ble_cmd_seq;
    localparam int DEPTH   = 4;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 64;
    localparam int FRAME   = 10;
    localparam int SPACING = FRAME + GAP + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_err;
    logic       full, empty, busy, ovf_err, to_err;
    logic [7:0] sent_cnt;

    ble_cmd_seq_if bus();

    ble_cmd_seq #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clr_err  (clr_err),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .sent_cnt (sent_cnt),
        .ovf_err  (ovf_err),
        .to_err   (to_err)
    );

    always #5 clk = ~clk;

    int         cyc;
    int         n_chk;
    int         n_bad;
    bit         hang;
    int         mcnt;
    int         mclr;
    bit         mact;
    int         n_trmt;
    logic [7:0] log_dat[$];
    int         log_cyc[$];
    logic [7:0] burst_exp [6] = '{8'h2e, 8'h67, 8'h73, 8'h67, 8'h73, 8'h99};

    // UART_tx stand-in: tx_done rises FRAME cycles after trmt and only drops two cycles after trmt.
    always @(negedge clk) begin
        if (rst) begin
            bus.tx_done = 1'b0;
            mact = 1'b0;
            mclr = 0;
            mcnt = 0;
        end else begin
            if (mclr > 0) begin
                mclr--;
                if (mclr == 0) bus.tx_done = 1'b0;
            end
            if (bus.trmt) begin
                mclr = 2;
                mact = 1'b1;
                mcnt = FRAME;
                n_trmt++;
                log_dat.push_back(bus.tx_data);
                log_cyc.push_back(cyc);
            end else if (mact && !hang) begin
                mcnt--;
                if (mcnt == 0) begin
                    bus.tx_done = 1'b1;
                    mact = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.push      = 1'b1;
        bus.push_data = b;
        tick();
        bus.push      = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.push = 1'b0;
        clr_err  = 1'b0;
        hang     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        log_dat.delete();
        log_cyc.delete();
    endtask

    initial begin
        int l0;
        int ln;
        int nt;
        cyc           = 0;
        n_chk         = 0;
        n_bad         = 0;
        n_trmt        = 0;
        rst           = 1'b1;
        clr_err       = 1'b0;
        hang          = 1'b0;
        bus.push      = 1'b0;
        bus.push_data = 8'h00;
        tick();
        tick();

        chk("rst_trmt",    bus.trmt,    1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_full",    full,        1'b0);
        chk("rst_empty",   empty,       1'b1);
        chk("rst_busy",    busy,        1'b0);
        chk("rst_sent",    sent_cnt,    8'd0);
        chk("rst_ovf",     ovf_err,     1'b0);
        chk("rst_to",      to_err,      1'b0);
        rst = 1'b0;

        // single byte: push in N, trmt only in N+2
        tick();
        push_byte(8'h67);
        chk("one_trmt_n1",  bus.trmt, 1'b0);
        chk("one_empty_n1", empty,    1'b0);
        tick();
        l0 = cyc;
        chk("one_trmt_n2",  bus.trmt,    1'b1);
        chk("one_data",     bus.tx_data, 8'h67);
        chk("one_empty_n2", empty,       1'b1);
        tick();
        chk("one_pulse",    bus.trmt,    1'b0);
        tick_to(l0 + FRAME);
        chk("one_sent_pre", sent_cnt, 8'd0);
        tick();
        chk("one_sent",     sent_cnt, 8'd1);
        tick_to(l0 + FRAME + GAP);
        chk("one_busy_gap", busy, 1'b1);
        tick();
        chk("one_busy_end", busy, 1'b0);
        chk("one_ntrmt",    n_trmt, 1);

        // burst behind an in-flight byte, then a push that coincides with a pop from a full queue
        do_reset();
        tick();
        push_byte(8'h2e);
        tick();
        l0 = cyc;
        push_byte(8'h67);
        push_byte(8'h73);
        push_byte(8'h67);
        chk("burst_full3", full, 1'b0);
        push_byte(8'h73);
        chk("burst_full4", full, 1'b1);
        chk("burst_ovf4",  ovf_err, 1'b0);
        tick_to(l0 + SPACING - 1);
        chk("burst_idle",  busy, 1'b0);
        push_byte(8'h99);
        chk("pp_trmt",     bus.trmt,    1'b1);
        chk("pp_data",     bus.tx_data, 8'h67);
        chk("pp_full",     full,        1'b1);
        chk("pp_ovf",      ovf_err,     1'b0);
        for (int i = 0; i < 400 && !(empty && !busy); i++) tick();
        chk("burst_busy",  busy,     1'b0);
        chk("burst_empty", empty,    1'b1);
        chk("burst_sent",  sent_cnt, 8'd6);
        chk("burst_n",     log_dat.size(), 6);
        for (int k = 0; k < 6 && k < log_dat.size(); k++) begin
            chk($sformatf("burst_dat%0d", k), log_dat[k], burst_exp[k]);
            chk($sformatf("burst_cyc%0d", k), log_cyc[k], l0 + SPACING * k);
        end

        // overflow while held in WAIT_DONE, then timeout with a coincident clear
        do_reset();
        chk("ovf_sent_rst", sent_cnt, 8'd0);
        hang = 1'b1;
        tick();
        push_byte(8'h11);
        tick();
        ln = cyc;
        chk("ovf_trmt", bus.trmt, 1'b1);
        tick();
        push_byte(8'ha1);
        push_byte(8'ha2);
        push_byte(8'ha3);
        push_byte(8'ha4);
        chk("ovf_full",  full,    1'b1);
        chk("ovf_pre",   ovf_err, 1'b0);
        push_byte(8'ha5);
        chk("ovf_set",   ovf_err, 1'b1);
        chk("ovf_full5", full,    1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr",   ovf_err, 1'b0);
        tick_to(ln + TIMEOUT);
        chk("to_pre",    to_err, 1'b0);
        chk("to_busy",   busy,   1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_set_wins", to_err,   1'b1);
        chk("to_sent",     sent_cnt, 8'd0);
        tick_to(ln + TIMEOUT + GAP + 1);
        chk("to_next_pre", bus.trmt, 1'b0);
        tick();
        chk("to_next_trmt", bus.trmt,    1'b1);
        chk("to_next_data", bus.tx_data, 8'ha1);

        // asynchronous reset during WAIT_DONE with bytes still queued
        tick_to(ln + TIMEOUT + GAP + 5);
        chk("mid_busy",  busy,  1'b1);
        chk("mid_empty", empty, 1'b0);
        rst = 1'b1;
        #2;
        chk("mid_trmt",  bus.trmt,    1'b0);
        chk("mid_data",  bus.tx_data, 8'h00);
        chk("mid_full",  full,        1'b0);
        chk("mid_empty0", empty,      1'b1);
        chk("mid_busy0", busy,        1'b0);
        chk("mid_sent",  sent_cnt,    8'd0);
        chk("mid_ovf",   ovf_err,     1'b0);
        chk("mid_to",    to_err,      1'b0);
        tick();
        tick();
        rst  = 1'b0;
        hang = 1'b0;
        nt   = n_trmt;
        repeat (40) tick();
        chk("mid_quiet", n_trmt, nt);
        push_byte(8'h73);
        tick();
        chk("mid_new_trmt", bus.trmt,    1'b1);
        chk("mid_new_data", bus.tx_data, 8'h73);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
